// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a single-port data RAM: lane select, store
// replication, load extension, bus timeout. Optional macro MISALIGN_CHECK_EN traps misaligned accesses.
module mem_access_unit #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [3:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [31:0]       bus_rdata_i,
  output logic [31:0]       rdata_o,
  output logic              done_o,
  output logic              err_o,
  output logic              stallreq_o
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_t;

  localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic [3:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_err, w_err_nxt;
  logic [31:0]       r_rdata, w_rdata_nxt;
  logic              w_latch;
  logic              w_in_bus;
  logic [3:0]        w_sel;
  logic [31:0]       w_bwdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
`ifdef MISALIGN_CHECK_EN
  logic              w_misalign;

  // Byte accesses can never be misaligned; size 1x is a word.
  assign w_misalign = ((op_i[1:0] == 2'b01) && addr_i[0]) ||
                      (op_i[1] && (addr_i[1:0] != 2'b00));
`endif

  // Lane select and store replication from the latched request.
  always_comb begin
    w_sel    = 4'b1111;
    w_bwdata = r_wdata;
    unique case (r_op[1:0])
      2'b00: begin
        w_sel    = 4'b0001 << r_addr[1:0];
        w_bwdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_sel    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_bwdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_sel    = 4'b1111;
        w_bwdata = r_wdata;
      end
    endcase
  end

  always_comb begin
    w_byte = bus_rdata_i[7:0];
    unique case (r_addr[1:0])
      2'b00:   w_byte = bus_rdata_i[7:0];
      2'b01:   w_byte = bus_rdata_i[15:8];
      2'b10:   w_byte = bus_rdata_i[23:16];
      default: w_byte = bus_rdata_i[31:24];
    endcase
    w_half = r_addr[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    w_load = bus_rdata_i;
    unique case (r_op[1:0])
      2'b00:   w_load = r_op[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = r_op[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = bus_rdata_i;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_rdata_nxt = r_rdata;
    w_latch     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (req_i) begin
          w_latch     = 1'b1;
          w_err_nxt   = 1'b0;
          w_cnt_nxt   = 8'd0;
          w_state_nxt = StBus;
`ifdef MISALIGN_CHECK_EN
          if (w_misalign) begin
            w_state_nxt = StResp;
            w_err_nxt   = 1'b1;
            if (!op_i[3]) w_rdata_nxt = 32'd0;
          end
`endif
        end
      end
      StBus: begin
        if (bus_ack_i) begin
          w_state_nxt = StResp;
          if (!r_op[3]) w_rdata_nxt = w_load;
        end else if (r_cnt == LP_TO_LAST) begin
          w_state_nxt = StResp;
          w_err_nxt   = 1'b1;
          w_rdata_nxt = 32'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      StResp:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
      r_op    <= 4'd0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      r_rdata <= w_rdata_nxt;
      if (w_latch) begin
        r_op    <= op_i;
        r_addr  <= addr_i;
        r_wdata <= wdata_i;
      end
    end
  end

  // Bus outputs are gated by state so reset clears them without waiting for a clock.
  assign w_in_bus    = (r_state == StBus);
  assign bus_req_o   = w_in_bus;
  assign bus_we_o    = w_in_bus & r_op[3];
  assign bus_addr_o  = w_in_bus ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
  assign bus_sel_o   = w_in_bus ? w_sel : 4'd0;
  assign bus_wdata_o = w_in_bus ? w_bwdata : 32'd0;
  assign rdata_o     = r_rdata;
  assign done_o      = (r_state == StResp);
  assign err_o       = done_o & r_err;
  assign stallreq_o  = ((r_state == StIdle) & req_i) | w_in_bus;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes expected bus/response entries,
// a negedge monitor pops and compares them.
module tb_mem_access_unit;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wd;
    int          len;
  } bus_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_i = 1'b0;
  logic [3:0]  op_i = 4'd0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i = 1'b0;
  logic [31:0] bus_rdata_i = 32'd0;
  logic [31:0] rdata_o;
  logic        done_o, err_o, stallreq_o;

  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  bus_t  bus_q[$];
  resp_t resp_q[$];
  bus_t  cur;
  logic  have = 1'b0;
  logic  in_bus = 1'b0;
  int    blen = 0;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i), .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o),
    .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    resp_t r;
    if (bus_req_o) begin
      if (!in_bus) begin
        in_bus = 1'b1;
        blen   = 0;
        if (bus_q.size() == 0) begin
          have = 1'b0;
          chk("bus_req_unexpected", 32'(bus_req_o), 32'd0);
        end else begin
          cur  = bus_q.pop_front();
          have = 1'b1;
        end
      end
      blen++;
      if (have) begin
        chk("bus_we", 32'(bus_we_o), 32'(cur.we));
        chk("bus_addr", bus_addr_o, cur.addr);
        chk("bus_sel", 32'(bus_sel_o), 32'(cur.sel));
        chk("bus_wdata", bus_wdata_o, cur.wd);
      end
    end else if (in_bus) begin
      in_bus = 1'b0;
      if (have) chk("bus_req_len", 32'(blen), 32'(cur.len));
    end
    if (done_o) begin
      if (resp_q.size() == 0) begin
        chk("done_unexpected", 32'(done_o), 32'd0);
      end else begin
        r = resp_q.pop_front();
        chk("rdata", rdata_o, r.rd);
        chk("err", 32'(err_o), 32'(r.err));
        chk("done_cycle", 32'(cyc), 32'(r.cyc));
      end
    end
  end

  // waits < 0 means the RAM never acks; lat is the done_o cycle relative to accept edge N.
  task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input int waits, input logic [31:0] brd, input logic exp_bus,
                        input logic [3:0] sel, input logic [31:0] baddr,
                        input logic [31:0] bwd, input int len, input logic [31:0] exp_rd,
                        input logic exp_err, input int lat);
    bus_t  b;
    resp_t r;
    int    t;
    @(negedge clk);
    req_i   = 1'b1;
    op_i    = op;
    addr_i  = addr;
    wdata_i = wd;
    if (exp_bus) begin
      b.we = op[3]; b.addr = baddr; b.sel = sel; b.wd = bwd; b.len = len;
      bus_q.push_back(b);
    end
    #1 chk("stallreq_accept", 32'(stallreq_o), 32'd1);
    @(posedge clk);
    #1 req_i = 1'b0;
    r.rd = exp_rd; r.err = exp_err; r.cyc = cyc + lat - 1;
    resp_q.push_back(r);
    if (waits >= 0) begin
      repeat (waits) @(posedge clk);
      #1;
      bus_ack_i   = 1'b1;
      bus_rdata_i = brd;
      @(posedge clk);
      #1 bus_ack_i = 1'b0;
    end
    t = 0;
    while (resp_q.size() != 0 && t < 40) begin
      @(posedge clk);
      t++;
    end
    if (resp_q.size() != 0) begin
      chk("done_wait_expired", 32'(resp_q.size()), 32'd0);
      resp_q.delete();
      bus_q.delete();
    end
  endtask

  initial begin
    bus_t b;
    #12;
    chk("rst_bus_req", 32'(bus_req_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_sel", 32'(bus_sel_o), 32'd0);
    chk("rst_stall", 32'(stallreq_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // LB 0x103, zero-wait
    access(4'b0000, 32'h103, 32'h0, 0, 32'h80112233, 1'b1, 4'b1000, 32'h100, 32'h0, 1,
           32'hFFFFFF80, 1'b0, 2);
    // LHU 0x102, three waits
    access(4'b0101, 32'h102, 32'h0, 3, 32'h8001AAAA, 1'b1, 4'b1100, 32'h100, 32'h0, 4,
           32'h00008001, 1'b0, 5);
    // SB 0x101
    access(4'b1000, 32'h101, 32'h000000A5, 0, 32'h0, 1'b1, 4'b0010, 32'h100, 32'hA5A5A5A5, 1,
           32'h00008001, 1'b0, 2);
    // LH 0x200, one wait
    access(4'b0001, 32'h200, 32'h0, 1, 32'h1234F00D, 1'b1, 4'b0011, 32'h200, 32'h0, 2,
           32'hFFFFF00D, 1'b0, 3);
    // LBU 0x201
    access(4'b0100, 32'h201, 32'h0, 0, 32'h0000C300, 1'b1, 4'b0010, 32'h200, 32'h0, 1,
           32'h000000C3, 1'b0, 2);
    // SH 0x302
    access(4'b1001, 32'h302, 32'hDEADBEEF, 0, 32'h0, 1'b1, 4'b1100, 32'h300, 32'hBEEFBEEF, 1,
           32'h000000C3, 1'b0, 2);
    // SW 0x304
    access(4'b1010, 32'h304, 32'hCAFEF00D, 2, 32'h0, 1'b1, 4'b1111, 32'h304, 32'hCAFEF00D, 3,
           32'h000000C3, 1'b0, 4);
    // LW 0x400, two waits
    access(4'b0010, 32'h400, 32'h0, 2, 32'h07654321, 1'b1, 4'b1111, 32'h400, 32'h0, 3,
           32'h07654321, 1'b0, 4);
    // LW with no ack: 15 bus cycles then error
    access(4'b0010, 32'h500, 32'h0, -1, 32'h0, 1'b1, 4'b1111, 32'h500, 32'h0, 15,
           32'h0, 1'b1, 16);
`ifdef MISALIGN_CHECK_EN
    access(4'b0010, 32'h102, 32'h0, -1, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 0,
           32'h0, 1'b1, 1);
`else
    access(4'b0010, 32'h102, 32'h0, 0, 32'h12345678, 1'b1, 4'b1111, 32'h100, 32'h0, 1,
           32'h12345678, 1'b0, 2);
`endif

    // Reset during BUS: aborted access, two bus cycles seen, no done afterwards
    @(negedge clk);
    req_i = 1'b1; op_i = 4'b0010; addr_i = 32'h600; wdata_i = 32'h0;
    b.we = 1'b0; b.addr = 32'h600; b.sel = 4'b1111; b.wd = 32'h0; b.len = 2;
    bus_q.push_back(b);
    @(posedge clk);
    #1 req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_bus_req", 32'(bus_req_o), 32'd0);
    chk("abort_stall", 32'(stallreq_o), 32'd0);
    chk("abort_rdata", rdata_o, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) @(posedge clk);

    // LB 0x000 after reset
    access(4'b0000, 32'h000, 32'h0, 0, 32'h000000FF, 1'b1, 4'b0001, 32'h000, 32'h0, 1,
           32'hFFFFFFFF, 1'b0, 2);

    repeat (2) @(posedge clk);
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, data-memory byte-address width.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 15, maximum cycles bus_req_o waits for bus_ack_i; legal range 1..255.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_i  input  1  access request from MEM stage.
REQ-006 SHALL have port op_i  input  4  [3]=store, [2]=unsigned load, [1:0]=size (00 byte, 01 half, 10/11 word).
REQ-007 SHALL have port addr_i  input  ADDR_W  byte address.
REQ-008 SHALL have port wdata_i  input  32  store data, right-aligned.
REQ-009 SHALL have ports bus_req_o output 1, bus_we_o output 1, bus_addr_o output ADDR_W (word-aligned, [1:0]=00), bus_sel_o output 4, bus_wdata_o output 32, for the RAM request.
REQ-010 SHALL have ports bus_ack_i input 1 and bus_rdata_i input 32, for the RAM response.
REQ-011 SHALL have ports rdata_o output 32 (extended load data), done_o output 1 (completion pulse), err_o output 1 (qualified by done_o), stallreq_o output 1 (to pipeline controller).

Function
REQ-012 SHALL implement FSM states IDLE, BUS, RESP.
REQ-013 SHALL in IDLE accept req_i: latch op, addr, wdata; go to BUS, or to RESP with error when misaligned and MISALIGN_CHECK_EN is defined.
REQ-014 SHALL in BUS hold bus_req_o=1 with stable bus_we_o/bus_addr_o/bus_sel_o/bus_wdata_o until bus_ack_i=1, then go to RESP.
REQ-015 SHALL count BUS cycles; on reaching TIMEOUT_CYC without ack, drop bus_req_o, go to RESP with err_o=1 and rdata_o=0.
REQ-016 SHALL in RESP assert done_o=1 for exactly one cycle, then return to IDLE.
REQ-017 SHALL give latency req_i at edge N -> bus_req_o high N+1 -> ack at cycle M -> done_o at M+1; zero-wait ack gives done_o at N+2.
REQ-018 SHALL drive stallreq_o = (IDLE and req_i) or BUS, combinationally.
REQ-019 SHALL ignore req_i outside IDLE, and bus_ack_i outside BUS.
REQ-020 SHALL use little-endian lanes: byte sel=0001<<addr[1:0]; half sel=addr[1]?1100:0011; word sel=1111.
REQ-021 SHALL replicate store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-022 SHALL select load lane per address, sign-extend when op_i[2]=0, zero-extend otherwise; op_i[2] is ignored for word and for stores.
REQ-023 SHALL register bus_rdata_i into rdata_o on the ack edge and hold it until the next load completes; stores leave rdata_o unchanged.

Reset
REQ-024 SHALL on rst=0 immediately force state IDLE, timeout counter 0, and all outputs 0, including mid-transaction (bus_req_o drops asynchronously).
REQ-025 SHALL, after rst rises, not resume an aborted access and not emit done_o for it.

Configuration
REQ-026 SHALL honour macro MISALIGN_CHECK_EN: when defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 issues no bus cycle and signals done_o with err_o=1 one cycle after acceptance; when undefined, misaligned low address bits are ignored (half uses addr[1] only, word uses sel 1111) and the access proceeds normally.

Verification
REQ-027 SHALL show: LB at addr 0x103, ack 0-wait, bus_rdata 0x80112233 -> bus_sel 1000, done_o at N+2, rdata_o 0xFFFFFF80.
REQ-028 SHALL show: LHU at addr 0x102, ack after 3 waits, bus_rdata 0x8001AAAA -> sel 1100, done_o at N+5, rdata_o 0x00008001.
REQ-029 SHALL show: SB addr 0x101, wdata 0x000000A5 -> bus_we 1, sel 0010, bus_wdata 0xA5A5A5A5, rdata_o unchanged.
REQ-030 SHALL show: LW with no ack, TIMEOUT_CYC=15 -> bus_req_o low after 15 cycles, done_o with err_o=1, rdata_o 0.
REQ-031 SHALL show: LW addr 0x102 -> with MISALIGN_CHECK_EN, no bus_req_o and err_o=1 at N+1; without, sel 1111, bus_addr 0x100.
REQ-032 SHALL show: rst low during BUS state -> bus_req_o 0 immediately, no done_o after release, next req_i serviced normally.
